// File: rtl/sum_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sum_pipe_pkg
// Brief    : Shared defaults and FSM state encodings for sum_pipe_arb.
// Revision : 1.0
// ============================================================================
package sum_pipe_pkg;

    localparam int DEF_NREQ    = 4;
    localparam int DEF_WIDTH   = 4;
    localparam int DEF_LATENCY = 3;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/sum_pipe_arb_if.sv
`default_nettype none
// ============================================================================
// Module   : sum_pipe_arb_if
// Brief    : Requester, adder and response signals of the shared-adder arbiter.
// Revision : 1.0
// ============================================================================
interface sum_pipe_arb_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 4,
    parameter int IDW   = 2
);
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] req_dataA;
    logic [NREQ*WIDTH-1:0] req_dataB;
    logic                  hold;
    logic [NREQ-1:0]       gnt;
    logic [WIDTH-1:0]      add_dataA;
    logic [WIDTH-1:0]      add_dataB;
    logic [WIDTH-1:0]      add_sum;
    logic                  rsp_valid;
    logic [IDW-1:0]        rsp_id;
    logic [WIDTH-1:0]      rsp_sum;
    logic                  busy;

    modport slave (
        input  req, req_dataA, req_dataB, hold, add_sum,
        output gnt, add_dataA, add_dataB, rsp_valid, rsp_id, rsp_sum, busy
    );

    modport master (
        output req, req_dataA, req_dataB, hold, add_sum,
        input  gnt, add_dataA, add_dataB, rsp_valid, rsp_id, rsp_sum, busy
    );
endinterface
`default_nettype wire

// File: rtl/sum_pipe_arb_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Brief    : Combinational round-robin one-hot selector starting at ptr.
// Revision : 1.0
// ============================================================================
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  idx,
    output logic            found
);

    int w_j;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        w_j   = 0;
        for (int k = 0; k < NREQ; k++) begin
            w_j = (int'(ptr) + k) % NREQ;
            if (!found && req[w_j]) begin
                found    = 1'b1;
                gnt[w_j] = 1'b1;
                idx      = IDW'(w_j);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/sum_pipe_arb.sv
`default_nettype none
// ============================================================================
// Module   : sum_pipe_arb
// Brief    : Round-robin sharing of one pipelined adder with ID-tagged results.
// Revision : 1.0
// ============================================================================
module sum_pipe_arb
    import sum_pipe_pkg::*;
#(
    parameter int NREQ    = DEF_NREQ,
    parameter int WIDTH   = DEF_WIDTH,
    parameter int LATENCY = DEF_LATENCY,
    parameter int IDW     = $clog2(NREQ)
) (
    input  logic           clk,
    input  logic           reset_L,
    sum_pipe_arb_if.slave  bus
);

    localparam int CW = $clog2(LATENCY + 1);

    state_t            r_state;
    state_t            w_state_nx;
    logic [CW-1:0]     r_init_cnt;
    logic [IDW-1:0]    r_ptr;
    logic [WIDTH-1:0]  r_add_a;
    logic [WIDTH-1:0]  r_add_b;
    logic [LATENCY:0]  r_tag_v;
    logic [IDW-1:0]    r_tag_id [0:LATENCY];

    logic [NREQ-1:0]   w_pick_gnt;
    logic [IDW-1:0]    w_pick_idx;
    logic              w_pick_any;
    logic              w_grant;

    rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .req   (bus.req),
        .ptr   (r_ptr),
        .gnt   (w_pick_gnt),
        .idx   (w_pick_idx),
        .found (w_pick_any)
    );

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_state    <= ST_INIT;
            r_init_cnt <= '0;
        end else begin
            r_state <= w_state_nx;
            if (r_state == ST_INIT && w_state_nx == ST_INIT)
                r_init_cnt <= r_init_cnt + 1'b1;
        end
    end

    // INIT waits out the adder's delayed reset before any operand is issued.
    always_comb begin
        w_state_nx = r_state;
        w_grant    = 1'b0;
        bus.gnt    = '0;
        case (r_state)
            ST_INIT: begin
                if (r_init_cnt == CW'(LATENCY - 1))
                    w_state_nx = bus.hold ? ST_HOLD : ST_RUN;
            end
            ST_RUN: begin
                w_grant = w_pick_any;
                bus.gnt = w_pick_gnt;
                if (bus.hold)
                    w_state_nx = ST_HOLD;
            end
            ST_HOLD: begin
                if (!bus.hold)
                    w_state_nx = ST_RUN;
            end
            default: w_state_nx = ST_INIT;
        endcase
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_ptr   <= '0;
            r_add_a <= '0;
            r_add_b <= '0;
            r_tag_v <= '0;
            for (int k = 0; k <= LATENCY; k++)
                r_tag_id[k] <= '0;
        end else begin
            if (w_grant) begin
                r_ptr   <= (w_pick_idx == IDW'(NREQ - 1)) ? '0 : w_pick_idx + 1'b1;
                r_add_a <= bus.req_dataA[w_pick_idx*WIDTH +: WIDTH];
                r_add_b <= bus.req_dataB[w_pick_idx*WIDTH +: WIDTH];
            end
            // Tag pipe free-runs so in-flight results drain even under hold.
            r_tag_v     <= {r_tag_v[LATENCY-1:0], w_grant};
            r_tag_id[0] <= w_grant ? w_pick_idx : '0;
            for (int k = 1; k <= LATENCY; k++)
                r_tag_id[k] <= r_tag_id[k-1];
        end
    end

    assign bus.add_dataA = r_add_a;
    assign bus.add_dataB = r_add_b;
    assign bus.rsp_valid = r_tag_v[LATENCY];
    assign bus.rsp_id    = r_tag_id[LATENCY];
    assign bus.rsp_sum   = bus.add_sum;
    assign bus.busy      = (r_state == ST_INIT) || (|r_tag_v);

endmodule
`default_nettype wire

// File: tb/tb_sum_pipe_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_sum_pipe_arb
// Brief    : Vector-table and scoreboard bench for sum_pipe_arb with adder model.
// Revision : 1.0
// ============================================================================
module tb_sum_pipe_arb;

    logic clk     = 1'b0;
    logic reset_L = 1'b0;
    int   checks  = 0;
    int   errors  = 0;
    int   cyc     = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sum_pipe_arb_if #(.NREQ(4), .WIDTH(4), .IDW(2)) bus ();

    sum_pipe_arb #(.NREQ(4), .WIDTH(4), .LATENCY(3), .IDW(2)) dut (
        .clk     (clk),
        .reset_L (reset_L),
        .bus     (bus)
    );

    // Three-stage adder: operands in, sum out three edges later.
    logic [3:0] s1, s2, s3;
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            s1 <= '0; s2 <= '0; s3 <= '0;
        end else begin
            s1 <= bus.add_dataA + bus.add_dataB;
            s2 <= s1;
            s3 <= s2;
        end
    end
    assign bus.add_sum = s3;

    logic [3:0] op_a [4] = '{4'd3, 4'd5, 4'd9, 4'd15};
    logic [3:0] op_b [4] = '{4'd4, 4'd6, 4'd8, 4'd15};

    typedef struct {
        logic [1:0] id;
        logic [3:0] sum;
        int         due;
    } exp_t;
    exp_t sb [$];

    typedef struct {
        logic [3:0] req;
        logic       hold;
        logic [3:0] gnt;
        logic       chk_busy;
        logic       busy;
    } vec_t;
    vec_t vecs [64];
    int   nvec = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic add_vec(input logic [3:0] r, input logic h, input logic [3:0] g,
                           input logic cb, input logic b);
        vecs[nvec] = '{req: r, hold: h, gnt: g, chk_busy: cb, busy: b};
        nvec++;
    endtask

    // Drive one cycle, check grant at negedge and schedule the tagged result.
    task automatic step(input logic [3:0] r, input logic h, input logic [3:0] eg,
                        input logic cb, input logic eb);
        exp_t e;
        bus.req  = r;
        bus.hold = h;
        @(negedge clk);
        check("gnt", bus.gnt, eg);
        if (cb) check("busy", bus.busy, eb);
        for (int i = 0; i < 4; i++) begin
            if (eg[i]) begin
                e.id  = 2'(i);
                e.sum = 4'((5'(op_a[i]) + 5'(op_b[i])) % 16);
                e.due = cyc + 4;
                sb.push_back(e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0 && sb[0].due == cyc) begin
            check("rsp_valid", bus.rsp_valid, 1);
            check("rsp_id", bus.rsp_id, sb[0].id);
            check("rsp_sum", bus.rsp_sum, sb[0].sum);
            void'(sb.pop_front());
        end else begin
            check("no_rsp", bus.rsp_valid, 0);
        end
    end

    initial begin
        bus.req  = 4'b0001;
        bus.hold = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.req_dataA[i*4 +: 4] = op_a[i];
            bus.req_dataB[i*4 +: 4] = op_b[i];
        end

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_gnt", bus.gnt, 0);
        check("rst_busy", bus.busy, 1);
        check("rst_rsp_id", bus.rsp_id, 0);
        check("rst_add_a", bus.add_dataA, 0);
        check("rst_add_b", bus.add_dataB, 0);
        @(posedge clk);
        #1;
        reset_L = 1'b1;

        // INIT wait: three idle cycles, then grant to requester 0
        step(4'b0001, 0, 4'b0000, 1, 1);
        step(4'b0001, 0, 4'b0000, 0, 0);
        step(4'b0001, 0, 4'b0000, 0, 0);
        step(4'b0001, 0, 4'b0001, 0, 0);

        // pointer now 1: overflow from requester 2
        add_vec(4'b0100, 0, 4'b0100, 0, 0);
        add_vec(4'b0000, 0, 4'b0000, 0, 0);
        // sparse requests: pointer ends at 0
        add_vec(4'b0100, 0, 4'b0100, 0, 0);
        add_vec(4'b1000, 0, 4'b1000, 0, 0);
        // full load, eight grants in rotation
        for (int k = 0; k < 8; k++)
            add_vec(4'b1111, 0, 4'(1 << (k % 4)), 0, 0);
        add_vec(4'b0000, 0, 4'b0000, 1, 1);
        for (int k = 0; k < 3; k++)
            add_vec(4'b0000, 0, 4'b0000, 0, 0);
        add_vec(4'b0000, 0, 4'b0000, 1, 0);
        // hold with two ops in flight
        add_vec(4'b1111, 0, 4'b0001, 0, 0);
        add_vec(4'b1111, 1, 4'b0010, 0, 0);
        for (int k = 0; k < 4; k++)
            add_vec(4'b1111, 1, 4'b0000, 0, 0);
        add_vec(4'b1111, 1, 4'b0000, 1, 0);
        add_vec(4'b1111, 0, 4'b0000, 0, 0);
        add_vec(4'b1111, 0, 4'b0100, 0, 0);
        add_vec(4'b1111, 0, 4'b1000, 0, 0);
        for (int k = 0; k < 5; k++)
            add_vec(4'b0000, 0, 4'b0000, 0, 0);

        for (int v = 0; v < nvec; v++)
            step(vecs[v].req, vecs[v].hold, vecs[v].gnt, vecs[v].chk_busy, vecs[v].busy);

        // Reset pulse with three ops in flight
        step(4'b1111, 0, 4'b0001, 0, 0);
        step(4'b1111, 0, 4'b0010, 0, 0);
        step(4'b1111, 0, 4'b0100, 0, 0);
        reset_L = 1'b0;
        sb.delete();
        #1;
        check("prst_gnt", bus.gnt, 0);
        check("prst_rsp_valid", bus.rsp_valid, 0);
        check("prst_add_a", bus.add_dataA, 0);
        check("prst_add_b", bus.add_dataB, 0);
        check("prst_busy", bus.busy, 1);
        repeat (2) @(posedge clk);
        #1;
        reset_L = 1'b1;
        step(4'b1111, 0, 4'b0000, 1, 1);
        step(4'b1111, 0, 4'b0000, 0, 0);
        step(4'b1111, 0, 4'b0000, 0, 0);
        step(4'b1111, 0, 4'b0001, 0, 0);
        for (int k = 0; k < 6; k++)
            step(4'b0000, 0, 4'b0000, 0, 0);
        step(4'b0000, 0, 4'b0000, 1, 0);

        check("sb_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
